// File: rtl/fft_frame_collector.sv
// AXI-Stream collector that gathers FFT output bins into a two-bank ping-pong
// frame buffer, validates tlast framing, and serves completed frames through a
// registered random-read port.
module fft_frame_collector #(
   parameter int unsigned DATAWIDTH = 48,
   parameter int unsigned FRAME_LEN = 1024
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [DATAWIDTH-1:0]         s_axis_tdata,
   input  logic                         s_axis_tvalid,
   output logic                         s_axis_tready,
   input  logic                         s_axis_tlast,
   output logic                         frame_ready,
   input  logic                         frame_ack,
   input  logic [$clog2(FRAME_LEN)-1:0] rd_addr,
   input  logic                         rd_en,
   output logic [DATAWIDTH-1:0]         rd_data,
   output logic                         rd_valid,
   output logic [15:0]                  frame_count,
   output logic                         err_tlast_early,
   output logic                         err_tlast_missing
);

   localparam int unsigned ADDR_W = $clog2(FRAME_LEN);
   localparam int unsigned CNT_W  = 16;
   localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(FRAME_LEN - 1);

   typedef enum logic {
      S_FILL = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic                run_q;
   logic [ADDR_W-1:0]   bin_cnt_q, bin_cnt_d;
   logic                wr_bank_q, wr_bank_d;
   logic                rd_bank_q, rd_bank_d;
   logic [1:0]          full_q, full_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                early_q, early_d;
   logic                miss_q, miss_d;
   logic                beat;
   logic                ack_hit;
   logic                other_free;

   logic [DATAWIDTH-1:0] mem [2*FRAME_LEN];

   // run_q holds tready low until the first clock after reset release
   assign s_axis_tready     = run_q && (state_q == S_FILL);
   assign frame_ready       = full_q[rd_bank_q];
   assign frame_count       = count_q;
   assign err_tlast_early   = early_q;
   assign err_tlast_missing = miss_q;

   assign beat    = s_axis_tvalid && s_axis_tready;
   assign ack_hit = frame_ack && full_q[rd_bank_q];
   // The bank after wr_bank is free now, or is being released this very cycle
   assign other_free = !full_q[~wr_bank_q] || (ack_hit && (rd_bank_q != wr_bank_q));

   // Next-state logic for writer FSM, bank flags, counters and error pulses
   always_comb begin
      state_d   = state_q;
      bin_cnt_d = bin_cnt_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      full_d    = full_q;
      count_d   = count_q;
      early_d   = 1'b0;
      miss_d    = 1'b0;

      if (ack_hit) begin
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = ~rd_bank_q;
      end

      unique case (state_q)
         S_FILL: begin
            if (beat) begin
               if (bin_cnt_q == LAST_BIN) begin
                  full_d[wr_bank_q] = 1'b1;
                  count_d           = count_q + CNT_W'(1);
                  bin_cnt_d         = '0;
                  miss_d            = !s_axis_tlast;
                  if (other_free) begin
                     wr_bank_d = ~wr_bank_q;
                  end else begin
                     state_d = S_WAIT;
                  end
               end else if (s_axis_tlast) begin
                  early_d   = 1'b1;
                  bin_cnt_d = '0;
               end else begin
                  bin_cnt_d = bin_cnt_q + ADDR_W'(1);
               end
            end
         end
         S_WAIT: begin
            if (other_free) begin
               wr_bank_d = ~wr_bank_q;
               state_d   = S_FILL;
            end
         end
         default: state_d = S_FILL;
      endcase
   end

   // Control state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FILL;
         run_q     <= 1'b0;
         bin_cnt_q <= '0;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         full_q    <= '0;
         count_q   <= '0;
         early_q   <= 1'b0;
         miss_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         run_q     <= 1'b1;
         bin_cnt_q <= bin_cnt_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         full_q    <= full_d;
         count_q   <= count_d;
         early_q   <= early_d;
         miss_q    <= miss_d;
      end
   end

   // Frame buffer write port; bins stored verbatim
   always_ff @(posedge clk) begin
      if (beat) begin
         mem[{wr_bank_q, bin_cnt_q}] <= s_axis_tdata;
      end
   end

   // Registered read port from the current read bank
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) begin
            rd_data <= mem[{rd_bank_q, rd_addr}];
         end
      end
   end

endmodule

// File: tb/tb_fft_frame_collector.sv
// Bench for fft_frame_collector (FRAME_LEN=8): directed scenarios plus a random
// soak, checked every cycle against a frame-level queue model.
module tb_fft_frame_collector;

   localparam int unsigned DW = 48;
   localparam int unsigned FL = 8;

   typedef logic [DW-1:0] frame_t [FL];

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] s_axis_tdata = '0;
   logic          s_axis_tvalid = 1'b0;
   logic          s_axis_tready;
   logic          s_axis_tlast = 1'b0;
   logic          frame_ready;
   logic          frame_ack = 1'b0;
   logic [2:0]    rd_addr = '0;
   logic          rd_en = 1'b0;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic [15:0]   frame_count;
   logic          err_tlast_early;
   logic          err_tlast_missing;

   fft_frame_collector #(.DATAWIDTH(DW), .FRAME_LEN(FL)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .s_axis_tdata      (s_axis_tdata),
      .s_axis_tvalid     (s_axis_tvalid),
      .s_axis_tready     (s_axis_tready),
      .s_axis_tlast      (s_axis_tlast),
      .frame_ready       (frame_ready),
      .frame_ack         (frame_ack),
      .rd_addr           (rd_addr),
      .rd_en             (rd_en),
      .rd_data           (rd_data),
      .rd_valid          (rd_valid),
      .frame_count       (frame_count),
      .err_tlast_early   (err_tlast_early),
      .err_tlast_missing (err_tlast_missing)
   );

   always #5 clk = ~clk;

   // Reference model: bins of the frame in progress and completed frames awaiting ack
   logic [DW-1:0] cur_q [$];
   frame_t        done_q [$];
   logic [15:0]   exp_cnt = '0;
   logic          run = 1'b0;
   logic          exp_early = 1'b0;
   logic          exp_miss = 1'b0;
   logic          exp_rv = 1'b0;
   logic          exp_known = 1'b0;
   logic [DW-1:0] exp_rd = '0;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("tready", 64'(s_axis_tready), 64'(run && (done_q.size() < 2)));
      chk("frame_ready", 64'(frame_ready), 64'(done_q.size() > 0));
      chk("frame_count", 64'(frame_count), 64'(exp_cnt));
      chk("err_tlast_early", 64'(err_tlast_early), 64'(exp_early));
      chk("err_tlast_missing", 64'(err_tlast_missing), 64'(exp_miss));
      chk("rd_valid", 64'(rd_valid), 64'(exp_rv));
      if (exp_rv && exp_known) chk("rd_data", 64'(rd_data), 64'(exp_rd));
   endtask

   // One clock: drive inputs, advance the model across the edge, check outputs
   task automatic cycle(input logic v, input logic [DW-1:0] d, input logic l,
                        input logic ack, input logic re, input logic [2:0] ra,
                        output logic took);
      logic tr;
      logic ack_hit;
      frame_t f;
      s_axis_tvalid = v;
      s_axis_tdata  = d;
      s_axis_tlast  = l;
      frame_ack     = ack;
      rd_en         = re;
      rd_addr       = ra;

      tr        = run && (done_q.size() < 2);
      took      = v && tr;
      ack_hit   = ack && (done_q.size() > 0);
      exp_rv    = re;
      exp_known = re && (done_q.size() > 0);
      if (exp_known) begin
         f      = done_q[0];
         exp_rd = f[ra];
      end
      exp_early = 1'b0;
      exp_miss  = 1'b0;
      if (took) begin
         cur_q.push_back(d);
         if (cur_q.size() == FL) begin
            for (int i = 0; i < FL; i++) f[i] = cur_q[i];
            done_q.push_back(f);
            exp_cnt  = exp_cnt + 16'd1;
            exp_miss = !l;
            cur_q.delete();
         end else if (l) begin
            exp_early = 1'b1;
            cur_q.delete();
         end
      end
      if (ack_hit) done_q.delete(0);
      run = 1'b1;

      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   task automatic idle(input int n);
      logic t;
      for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 3'd0, t);
   endtask

   task automatic send_bin(input logic [DW-1:0] d, input logic l, input logic ack);
      logic t;
      t = 1'b0;
      for (int k = 0; k < 40 && !t; k++) cycle(1'b1, d, l, ack, 1'b0, 3'd0, t);
      if (!t) begin
         checks++;
         errors++;
         $error("FAIL send_timeout observed=stalled expected=accepted");
      end
   endtask

   // n bins of random data, tlast on bin last_at, optional ack on the final bin
   task automatic send_frame(input int n, input int last_at, input logic ack_last);
      for (int i = 0; i < n; i++)
         send_bin(DW'({$urandom, $urandom}), (i == last_at), ack_last && (i == n - 1));
   endtask

   task automatic read_and_ack();
      logic t;
      for (int i = 0; i < FL; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 3'(i), t);
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 3'd0, t);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      frame_ack     = 1'b0;
      rd_en         = 1'b0;
      cur_q.delete();
      done_q.delete();
      exp_cnt = '0;
      run = 1'b0;
      exp_rv = 1'b0;
      exp_early = 1'b0;
      exp_miss = 1'b0;
      #1;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_all();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic t;
      do_reset();
      idle(1);

      // Frame of bins 0..7, read back and release
      for (int i = 0; i < FL; i++) send_bin(DW'(i), (i == FL - 1), 1'b0);
      read_and_ack();

      // Three frames without ack: third held off until an ack
      send_frame(FL, FL - 1, 1'b0);
      send_frame(FL, FL - 1, 1'b0);
      idle(3);
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 3'd0, t);
      send_frame(FL, FL - 1, 1'b0);
      read_and_ack();
      read_and_ack();

      // Early tlast discards, then a clean frame
      send_frame(5, 4, 1'b0);
      send_frame(FL, FL - 1, 1'b0);
      read_and_ack();

      // Missing tlast still commits
      send_frame(FL, -1, 1'b0);
      read_and_ack();

      // Both banks full, ack while stalled, then commit coinciding with ack
      send_frame(FL, FL - 1, 1'b0);
      send_frame(FL, FL - 1, 1'b0);
      idle(2);
      cycle(1'b1, DW'(48'h123456789abc), 1'b0, 1'b1, 1'b0, 3'd0, t);
      for (int i = 1; i < FL; i++) send_bin(DW'({$urandom, $urandom}), (i == FL - 1), 1'b0);
      send_frame(FL, FL - 1, 1'b1);
      send_frame(FL, FL - 1, 1'b0);
      read_and_ack();
      read_and_ack();

      // Reset mid-frame, then a fresh frame
      send_frame(4, -1, 1'b0);
      do_reset();
      send_frame(FL, FL - 1, 1'b0);
      read_and_ack();

      // Random soak
      for (int c = 0; c < 600; c++) begin
         logic v, l, ack, re;
         logic [2:0] ra;
         v   = ($urandom % 4) != 0;
         l   = (cur_q.size() == FL - 1) ? (($urandom % 8) != 0) : (($urandom % 40) == 0);
         ack = ($urandom % 6) == 0;
         re  = ($urandom % 2) == 0;
         ra  = 3'($urandom);
         cycle(v, DW'({$urandom, $urandom}), l, ack, re, ra, t);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
